// File: rtl/spike_aer_if.sv
// spike_aer_if - address-event stream between the spike encoder and its consumer.
//
// Signals:
//   ev_valid  head event word available (encoder -> consumer)
//   ev_ready  consumer accepts the head word when high with ev_valid
//   ev_id     neuron index of the head event
//   ev_ts     capture timestamp of the head event
// Modports: master (encoder side), slave (consumer side).
interface spike_aer_if #(
  parameter int ID_W = 2,
  parameter int TS_W = 16
) ();
  logic            ev_valid;
  logic            ev_ready;
  logic [ID_W-1:0] ev_id;
  logic [TS_W-1:0] ev_ts;

  modport master (output ev_valid, output ev_id, output ev_ts, input ev_ready);
  modport slave  (input ev_valid, input ev_id, input ev_ts, output ev_ready);
endinterface

// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder - captures one-cycle spike pulses from NUM_NEURONS neurons,
// arbitrates them round-robin into a show-ahead FIFO of address events and
// presents them on a valid/ready stream. Spikes arriving while a neuron's
// previous event is still pending are counted in a saturating drop counter.
//
// Optional feature macro: SPIKE_AER_TS_EN. When defined, each event carries the
// value of a free-running TS_W-bit cycle counter taken in the spike cycle;
// when undefined no timestamp state exists and ev_ts is constant 0.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   spike_in    per-neuron spike pulses
//   ev          spike_aer_if.master event stream (ev_valid/ev_ready/ev_id/ev_ts)
//   fifo_count  events currently buffered
//   drop_cnt    saturating count of dropped spikes
module spike_aer_encoder #(
  parameter int NUM_NEURONS = 4,
  parameter int ID_W        = $clog2(NUM_NEURONS),
  parameter int TS_W        = 16,
  parameter int DEPTH       = 8,
  parameter int DROP_W      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_NEURONS-1:0]   spike_in,
  spike_aer_if.master              ev,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = DROP_W + ID_W + 1;
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};
  localparam logic [NUM_NEURONS-1:0] ONE_N = {{(NUM_NEURONS-1){1'b0}}, 1'b1};

  // Returns {found, index} of the first set bit at or above start, wrapping.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_NEURONS-1:0] pend,
                                           input logic [ID_W-1:0] start);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] idx;
    res = {(ID_W+1){1'b0}};
    // Scan from the farthest offset down so the nearest hit is written last.
    for (int k = NUM_NEURONS - 1; k >= 0; k--) begin
      idx = ID_W'((int'(start) + k) % NUM_NEURONS);
      res = pend[idx] ? {1'b1, idx} : res;
    end
    return res;
  endfunction

  // Number of set bits in a spike vector.
  function automatic logic [ID_W:0] popcnt(input logic [NUM_NEURONS-1:0] v);
    logic [ID_W:0] cnt;
    cnt = {(ID_W+1){1'b0}};
    for (int i = 0; i < NUM_NEURONS; i++) begin
      cnt = cnt + {{ID_W{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  logic [NUM_NEURONS-1:0] pending_r;
  logic [ID_W-1:0]        ptr_r;
  logic [DROP_W-1:0]      drop_cnt_r;
  logic [CW-1:0]          fifo_count_r;
  logic                   ev_valid_r;
  logic [AW-1:0]          wr_ptr_r;
  logic [AW-1:0]          rd_ptr_r;
  logic [ID_W-1:0]        id_mem_r [DEPTH];

  logic [ID_W:0]          pick_s;
  logic                   grant_s;
  logic [ID_W-1:0]        grant_idx_s;
  logic [ID_W-1:0]        next_ptr_s;
  logic [NUM_NEURONS-1:0] grant_mask_s;
  logic [NUM_NEURONS-1:0] held_s;
  logic [NUM_NEURONS-1:0] drop_s;
  logic [NUM_NEURONS-1:0] pending_next_s;
  logic [SW-1:0]          drop_sum_s;
  logic [DROP_W-1:0]      drop_next_s;
  logic                   push_s;
  logic                   pop_s;
  logic [CW-1:0]          count_next_s;

  // Arbitration, capture/drop classification and FIFO occupancy next-state.
  always_comb begin
    pick_s      = rr_pick(pending_r, ptr_r);
    grant_idx_s = pick_s[ID_W-1:0];
    // A full FIFO blocks the grant even when a pop happens in the same cycle.
    grant_s     = pick_s[ID_W] && (fifo_count_r != CW'(DEPTH));
    if (grant_s) begin
      grant_mask_s = ONE_N << grant_idx_s;
    end else begin
      grant_mask_s = {NUM_NEURONS{1'b0}};
    end
    if (grant_idx_s == ID_W'(NUM_NEURONS - 1)) begin
      next_ptr_s = {ID_W{1'b0}};
    end else begin
      next_ptr_s = grant_idx_s + {{(ID_W-1){1'b0}}, 1'b1};
    end
    // Pending bits that survive this cycle; a spike on one of these is lost.
    held_s         = pending_r & ~grant_mask_s;
    drop_s         = spike_in & held_s;
    pending_next_s = held_s | spike_in;
    drop_sum_s     = {{(ID_W+1){1'b0}}, drop_cnt_r} + {{DROP_W{1'b0}}, popcnt(drop_s)};
    if (drop_sum_s > {{(ID_W+1){1'b0}}, DROP_MAX}) begin
      drop_next_s = DROP_MAX;
    end else begin
      drop_next_s = drop_sum_s[DROP_W-1:0];
    end
    push_s = grant_s;
    pop_s  = ev_valid_r && ev.ev_ready;
    case ({push_s, pop_s})
      2'b10:   count_next_s = fifo_count_r + {{AW{1'b0}}, 1'b1};
      2'b01:   count_next_s = fifo_count_r - {{AW{1'b0}}, 1'b1};
      default: count_next_s = fifo_count_r;
    endcase
  end

  // Pending flags, round-robin pointer and saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r  <= {NUM_NEURONS{1'b0}};
      ptr_r      <= {ID_W{1'b0}};
      drop_cnt_r <= {DROP_W{1'b0}};
    end else begin
      pending_r  <= pending_next_s;
      ptr_r      <= grant_s ? next_ptr_s : ptr_r;
      drop_cnt_r <= drop_next_s;
    end
  end

  // Event-id storage, FIFO pointers, occupancy and registered valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        id_mem_r[i] <= {ID_W{1'b0}};
      end
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      fifo_count_r <= {CW{1'b0}};
      ev_valid_r   <= 1'b0;
    end else begin
      if (push_s) begin
        id_mem_r[wr_ptr_r] <= grant_idx_s;
        wr_ptr_r           <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      fifo_count_r <= count_next_s;
      ev_valid_r   <= (count_next_s != {CW{1'b0}});
    end
  end

`ifdef SPIKE_AER_TS_EN
  logic [TS_W-1:0]        ts_r;
  logic [TS_W-1:0]        ts_reg_r [NUM_NEURONS];
  logic [TS_W-1:0]        ts_mem_r [DEPTH];
  logic [NUM_NEURONS-1:0] capture_s;

  // A spike is captured unless its neuron stays pending through this cycle.
  always_comb begin
    capture_s = spike_in & ~held_s;
  end

  // Free-running timestamp and per-neuron record of the spike cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_r <= {TS_W{1'b0}};
      for (int i = 0; i < NUM_NEURONS; i++) begin
        ts_reg_r[i] <= {TS_W{1'b0}};
      end
    end else begin
      ts_r <= ts_r + {{(TS_W-1){1'b0}}, 1'b1};
      for (int i = 0; i < NUM_NEURONS; i++) begin
        ts_reg_r[i] <= capture_s[i] ? ts_r : ts_reg_r[i];
      end
    end
  end

  // Timestamp field of the FIFO, written alongside the event id.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ts_mem_r[i] <= {TS_W{1'b0}};
      end
    end else begin
      if (push_s) begin
        ts_mem_r[wr_ptr_r] <= ts_reg_r[grant_idx_s];
      end
    end
  end

  assign ev.ev_ts = ts_mem_r[rd_ptr_r];
`else
  assign ev.ev_ts = {TS_W{1'b0}};
`endif

  assign ev.ev_valid  = ev_valid_r;
  assign ev.ev_id     = id_mem_r[rd_ptr_r];
  assign fifo_count   = fifo_count_r;
  assign drop_cnt     = drop_cnt_r;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// tb_spike_aer_encoder - directed self-checking bench for spike_aer_encoder.
// Cycle numbering: cycle 0 is the first clock cycle after reset release; the
// bench drives and samples on the falling edge inside each cycle.
module tb_spike_aer_encoder;
  localparam int NN = 4;
  localparam int IW = 2;
  localparam int TW = 4;
  localparam int DP = 8;
  localparam int DW = 2;
`ifdef SPIKE_AER_TS_EN
  localparam int TS_ON = 1;
`else
  localparam int TS_ON = 0;
`endif

  logic          clk;
  logic          rst;
  logic [NN-1:0] spike_in;
  logic [3:0]    fifo_count;
  logic [DW-1:0] drop_cnt;
  int            cyc;
  int            n_checks;
  int            n_errors;

  spike_aer_if #(.ID_W(IW), .TS_W(TW)) ev_if ();

  spike_aer_encoder #(
    .NUM_NEURONS(NN), .ID_W(IW), .TS_W(TW), .DEPTH(DP), .DROP_W(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .spike_in(spike_in),
    .ev(ev_if.master),
    .fifo_count(fifo_count),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int exp_ts(input int c);
    return (c % 16) * TS_ON;
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic pulse(input logic [NN-1:0] v);
    spike_in = v;
    tick();
    spike_in = 4'b0000;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc = 0;
    rst = 1'b1;
    spike_in = 4'b0000;
    ev_if.ev_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_valid", ev_if.ev_valid, 0);
    check_eq("rst_id", ev_if.ev_id, 0);
    check_eq("rst_ts", ev_if.ev_ts, 0);
    check_eq("rst_count", fifo_count, 0);
    check_eq("rst_drop", drop_cnt, 0);
    rst = 1'b0;
    cyc = 0;

    // Single spike on neuron 2 in cycle 10; ready held high without valid.
    ev_if.ev_ready = 1'b1;
    wait_cyc(10);
    pulse(4'b0100);
    check_eq("t1_c11_valid", ev_if.ev_valid, 0);
    tick();
    check_eq("t1_c12_valid", ev_if.ev_valid, 1);
    check_eq("t1_c12_id", ev_if.ev_id, 2);
    check_eq("t1_c12_ts", ev_if.ev_ts, exp_ts(10));
    tick();
    check_eq("t1_c13_valid", ev_if.ev_valid, 0);
    check_eq("t1_c13_count", fifo_count, 0);

    // Simultaneous spikes in cycle 5 -> ids 0..3 in cycles 7..10.
    do_reset();
    wait_cyc(5);
    pulse(4'b1111);
    wait_cyc(7);
    for (int k = 0; k < 4; k++) begin
      check_eq("t2_valid", ev_if.ev_valid, 1);
      check_eq("t2_id", ev_if.ev_id, k);
      check_eq("t2_ts", ev_if.ev_ts, exp_ts(5));
      tick();
    end
    check_eq("t2_c11_valid", ev_if.ev_valid, 0);
    // Pointer wrapped to 0: neuron 0 wins over neuron 3.
    wait_cyc(12);
    pulse(4'b1001);
    tick();
    check_eq("t2_c14_id", ev_if.ev_id, 0);
    check_eq("t2_c14_ts", ev_if.ev_ts, exp_ts(12));
    tick();
    check_eq("t2_c15_id", ev_if.ev_id, 3);

    // Backpressure, full FIFO, drops and drop-counter saturation.
    do_reset();
    ev_if.ev_ready = 1'b0;
    pulse(4'b1111);
    wait_cyc(5);
    check_eq("t3_c5_count", fifo_count, 4);
    check_eq("t3_c5_id", ev_if.ev_id, 0);
    check_eq("t3_c5_ts", ev_if.ev_ts, exp_ts(0));
    wait_cyc(6);
    pulse(4'b1111);
    wait_cyc(11);
    check_eq("t3_c11_count", fifo_count, 8);
    wait_cyc(12);
    pulse(4'b1111);
    check_eq("t3_c13_count", fifo_count, 8);
    check_eq("t3_c13_drop", drop_cnt, 0);
    wait_cyc(14);
    spike_in = 4'b0011;
    tick();
    check_eq("t3_c15_drop", drop_cnt, 2);
    tick();
    check_eq("t3_c16_drop", drop_cnt, 3);
    check_eq("t3_c16_count", fifo_count, 8);
    check_eq("t3_c16_id", ev_if.ev_id, 0);
    check_eq("t3_c16_ts", ev_if.ev_ts, exp_ts(0));
    tick();
    check_eq("t3_c17_drop", drop_cnt, 3);
    spike_in = 4'b0000;
    ev_if.ev_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check_eq("t3_drain_valid", ev_if.ev_valid, 1);
      check_eq("t3_drain_id", ev_if.ev_id, i % 4);
      check_eq("t3_drain_ts", ev_if.ev_ts, exp_ts((i < 4) ? 0 : ((i < 8) ? 6 : 12)));
      if (cyc == 22) check_eq("t3_c22_count", fifo_count, 7);
      tick();
    end
    check_eq("t3_end_valid", ev_if.ev_valid, 0);
    check_eq("t3_end_count", fifo_count, 0);
    check_eq("t3_end_drop", drop_cnt, 3);

    // Timestamp wrap: neuron 1 spikes in cycles 15 and 17.
    do_reset();
    wait_cyc(15);
    pulse(4'b0010);
    tick();
    check_eq("t4_c17_valid", ev_if.ev_valid, 1);
    check_eq("t4_c17_id", ev_if.ev_id, 1);
    check_eq("t4_c17_ts", ev_if.ev_ts, exp_ts(15));
    pulse(4'b0010);
    check_eq("t4_c18_valid", ev_if.ev_valid, 0);
    tick();
    check_eq("t4_c19_valid", ev_if.ev_valid, 1);
    check_eq("t4_c19_id", ev_if.ev_id, 1);
    check_eq("t4_c19_ts", ev_if.ev_ts, exp_ts(17));

    // Reset mid-stream with events buffered, neurons pending and a drop counted.
    do_reset();
    ev_if.ev_ready = 1'b0;
    pulse(4'b1111);
    wait_cyc(4);
    pulse(4'b1111);
    wait_cyc(6);
    check_eq("t5_c6_count", fifo_count, 5);
    pulse(4'b0100);
    check_eq("t5_c7_drop", drop_cnt, 1);
    check_eq("t5_c7_count", fifo_count, 6);
    rst = 1'b1;
    #1;
    check_eq("t5_rst_valid", ev_if.ev_valid, 0);
    check_eq("t5_rst_count", fifo_count, 0);
    check_eq("t5_rst_drop", drop_cnt, 0);
    check_eq("t5_rst_id", ev_if.ev_id, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    ev_if.ev_ready = 1'b1;
    tick();
    check_eq("t5_c1_valid", ev_if.ev_valid, 0);
    wait_cyc(3);
    pulse(4'b1000);
    tick();
    check_eq("t5_c5_valid", ev_if.ev_valid, 1);
    check_eq("t5_c5_id", ev_if.ev_id, 3);
    check_eq("t5_c5_ts", ev_if.ev_ts, exp_ts(3));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
